// File: rtl/mem_array_arbiter.sv
// 16x8 register array with a single access port shared by requesters A and B
// through round-robin req/gnt arbitration, plus a zero-fill clear sequencer.
module mem_array_arbiter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic              dbg_state
);

  // Handshake: a transfer happens at the rising edge where req && gnt; gnt is
  // combinational, a requester holds req (and its we/addr/wdata) until granted.
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_last_b;
  logic              r_clr_done;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  always_comb begin
    w_state_nxt = r_state;
    w_a_gnt     = 1'b0;
    w_b_gnt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Clear outranks pending requests; they simply keep waiting.
        if (clr_start) begin
          w_state_nxt = S_CLEAR;
        end else if (a_req && (!b_req || r_last_b)) begin
          w_a_gnt = 1'b1;
        end else if (b_req) begin
          w_b_gnt = 1'b1;
        end
      end
      S_CLEAR: begin
        if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Grants are held off while reset is asserted so no write can slip in.
    if (rst) begin
      w_a_gnt = 1'b0;
      w_b_gnt = 1'b0;
    end
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = a_addr;
    w_mem_wdata = a_wdata;
    if (r_state == S_CLEAR && !rst) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_clr_cnt;
      w_mem_wdata = '0;
    end else if (w_a_gnt) begin
      w_mem_we    = a_we;
    end else if (w_b_gnt) begin
      w_mem_we    = b_we;
      w_mem_addr  = b_addr;
      w_mem_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_clr_cnt  <= '0;
      r_last_b   <= 1'b1;
      r_clr_done <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_cnt  <= (r_state == S_CLEAR) ? r_clr_cnt + ADDR_W'(1) : '0;
      r_clr_done <= (r_state == S_CLEAR) && (w_state_nxt == S_IDLE);
      if (w_a_gnt || w_b_gnt) begin
        r_last_b <= w_b_gnt;
      end
      r_a_rvalid <= w_a_gnt && !a_we;
      r_b_rvalid <= w_b_gnt && !b_we;
      if (w_a_gnt && !a_we) begin
        r_a_rdata <= r_mem[a_addr];
      end
      if (w_b_gnt && !b_we) begin
        r_b_rdata <= r_mem[b_addr];
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign a_gnt     = w_a_gnt;
  assign b_gnt     = w_b_gnt;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign busy      = (r_state == S_CLEAR);
  assign clr_done  = r_clr_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_array_arbiter.sv
// Directed bench for mem_array_arbiter: clear, single access, round-robin,
// clear-vs-pending-request and reset during clear.
module tb_mem_array_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       clr_start = 1'b0;
  logic       busy, clr_done, dbg_state;

  int checks = 0;
  int failures = 0;

  mem_array_arbiter #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access by one requester with the other idle: grant expected at once,
  // read data checked the cycle after the grant.
  task automatic acc(input bit is_b, input bit we, input logic [3:0] addr,
                     input logic [7:0] wd, input logic [7:0] exp);
    if (is_b) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    #1;
    check(is_b ? "b_gnt" : "a_gnt", is_b ? b_gnt : a_gnt, 1);
    tick();
    a_req = 1'b0;
    b_req = 1'b0;
    #1;
    if (we) begin
      check("rvalid_on_write", {a_rvalid, b_rvalid}, 0);
    end else if (is_b) begin
      check("b_rvalid", b_rvalid, 1);
      check("b_rdata", b_rdata, exp);
      check("a_rvalid_quiet", a_rvalid, 0);
    end else begin
      check("a_rvalid", a_rvalid, 1);
      check("a_rdata", a_rdata, exp);
      check("b_rvalid_quiet", b_rvalid, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int na, nb;
    // Reset state, with A requesting to prove grants are held off.
    a_req = 1'b1;
    tick();
    #1;
    check("rst_a_gnt", a_gnt, 0);
    check("rst_b_gnt", b_gnt, 0);
    check("rst_rdata", {a_rdata, b_rdata}, 0);
    check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    check("rst_busy", busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_state", dbg_state, 0);
    a_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // 1: full clear, then all addresses read back zero.
    clr_start = 1'b1;
    #1;
    check("clr_start_busy", busy, 0);
    tick();
    clr_start = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("clr_busy", busy, 1);
      check("clr_no_gnt", {a_gnt, b_gnt}, 0);
      check("clr_done_early", clr_done, 0);
      tick();
    end
    a_req = 1'b0;
    #1;
    check("clr_busy_end", busy, 0);
    check("clr_done_pulse", clr_done, 1);
    tick();
    check("clr_done_once", clr_done, 0);
    for (int i = 0; i < 16; i++) begin
      acc(1'b0, 1'b0, 4'(i), 8'h00, 8'h00);
    end

    // 2: A write then read back.
    acc(1'b0, 1'b1, 4'd3, 8'h5A, 8'h00);
    acc(1'b0, 1'b0, 4'd3, 8'h00, 8'h5A);

    // 3: both requesting continuously after reset -> A,B,A,B,A,B.
    do_reset();
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd4; a_wdata = 8'h11;
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd5; b_wdata = 8'h22;
    na = 0;
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_a_gnt", a_gnt, (i % 2 == 0) ? 1 : 0);
      check("rr_b_gnt", b_gnt, (i % 2 == 1) ? 1 : 0);
      na += int'(a_gnt);
      nb += int'(b_gnt);
      tick();
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("rr_a_count", na, 3);
    check("rr_b_count", nb, 3);
    acc(1'b0, 1'b0, 4'd4, 8'h00, 8'h11);
    acc(1'b1, 1'b0, 4'd5, 8'h00, 8'h22);

    // 4: A alone every cycle, then B joins and wins next.
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("solo_a_gnt", a_gnt, 1);
      tick();
      check("solo_a_rvalid", a_rvalid, 1);
      check("solo_a_rdata", a_rdata, 8'h11);
    end
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd3;
    #1;
    check("fair_b_gnt", b_gnt, 1);
    check("fair_a_wait", a_gnt, 0);
    tick();
    b_req = 1'b0;
    #1;
    check("fair_a_next", a_gnt, 1);
    check("fair_b_rdata", b_rdata, 8'h5A);
    tick();
    a_req = 1'b0;

    // 5: read pending when clear starts waits 17 cycles, then sees zero.
    tick();
    acc(1'b0, 1'b1, 4'd9, 8'h77, 8'h00);
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd9;
    clr_start = 1'b1;
    na = 0;
    for (int i = 0; i < 17; i++) begin
      #1;
      na += int'(a_gnt);
      tick();
      clr_start = 1'b0;
    end
    check("pend_no_gnt", na, 0);
    #1;
    check("pend_gnt_in_done", a_gnt, 1);
    check("pend_done", clr_done, 1);
    tick();
    a_req = 1'b0;
    #1;
    check("pend_rvalid", a_rvalid, 1);
    check("pend_rdata", a_rdata, 8'h00);

    // 6: reset in clear cycle 8 keeps unvisited data, no clr_done.
    tick();
    acc(1'b0, 1'b1, 4'd12, 8'hFF, 8'h00);
    acc(1'b0, 1'b1, 4'd2, 8'h33, 8'h00);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_gnt", a_gnt, 0);
    check("mid_rst_done", clr_done, 0);
    tick();
    a_req = 1'b0;
    rst = 1'b0;
    na = 0;
    for (int i = 0; i < 10; i++) begin
      na += int'(clr_done);
      tick();
    end
    check("mid_no_clr_done", na, 0);
    acc(1'b0, 1'b0, 4'd12, 8'h00, 8'hFF);
    acc(1'b0, 1'b0, 4'd2, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_array_arbiter.md
Name: mem_array_arbiter

Overview:
Owns a 16x8 register array and shares its single access port between two requesters, A and B, using round-robin arbitration with a req/gnt handshake. Read data returns one cycle after the grant. A built-in clear sequencer zero-fills the array on command. Sits between the array datapath and its two client blocks and replaces direct pointer-driven access.

Parameters:
DATA_W, 8, width of each array entry and of the data buses
DEPTH, 16, number of array entries
ADDR_W, 4, address width; DEPTH must equal 2**ADDR_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
a_req  in  1  requester A access request; held high until granted
a_we  in  1  A: 1=write, 0=read; stable while a_req is high
a_addr  in  ADDR_W  A access address
a_wdata  in  DATA_W  A write data
a_gnt  out  1  A granted this cycle; combinational
a_rdata  out  DATA_W  A read data; registered
a_rvalid  out  1  A read data valid; 1-cycle pulse
b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid  same as the A ports, for requester B
clr_start  in  1  request a full-array zero fill
busy  out  1  clear sequence in progress
clr_done  out  1  1-cycle pulse when the clear sequence completes

Behaviour:
- Reset: a_gnt=b_gnt=0, a_rdata=b_rdata=0, a_rvalid=b_rvalid=0, busy=0, clr_done=0, state=IDLE, clear counter=0, last_grant=B so A wins the first tie. Array contents are not reset; they are undefined until the first clear or write.
- States are IDLE and CLEAR.
- IDLE grant rules, evaluated combinationally each cycle:
  - If clr_start=1, there is no grant this cycle and the next state is CLEAR. Clear takes priority over pending requests.
  - If only one requester has req=1, that requester is granted.
  - If both have req=1, the requester that is not last_grant is granted.
  - At most one grant per cycle.
  - last_grant updates at the clock edge of every grant.
- Transfer: a transfer occurs at the clock edge where req&&gnt=1.
  - Write: mem[addr] <= wdata at that edge.
  - Read: rdata <= mem[addr] and rvalid <= 1 at that edge, so data is visible the cycle after the grant.
  - rvalid is high for exactly one cycle. rdata holds its last value otherwise.
  - rvalid is never asserted for a write.
- Back-to-back: a requester holding req with the other idle is granted every cycle, giving 1 access/cycle throughput.
  - With both requesting continuously, grants alternate A,B,A,B.
  - A write granted in cycle N followed by a read of the same address granted in N+1 returns the new data.
- CLEAR: runs 16 cycles with counter 0..15.
  - Each cycle writes 0 to mem[counter]; counter increments.
  - busy=1 and a_gnt=b_gnt=0 throughout. clr_start is ignored while in CLEAR.
  - Pending reqs simply wait; they are not dropped.
  - After the write to address 15, the state returns to IDLE and counter resets to 0.
- clr_done: registered; high for the single first IDLE cycle after CLEAR. Grants are permitted in that cycle.
- Address wrap: the clear counter wraps 15->0 on exit. No out-of-range addresses exist, since ADDR_W covers DEPTH.
- Reset mid-operation:
  - Asynchronous return to the reset values above. An in-progress clear is aborted with no clr_done.
  - An rvalid due in the next cycle is suppressed.
  - The array keeps whatever was already written.
- busy = (state==CLEAR), driven from the state register.

Test Plan:
1. rst pulse, then clr_start for 1 cycle -> busy=1 for exactly 16 cycles, no gnts, clr_done high 1 cycle after; reads of addr 0..15 all return 0x00.
2. A writes 0x5A to addr 3 (a_gnt same cycle), then A reads addr 3 -> a_rvalid=1 with a_rdata=0x5A exactly 1 cycle after the read grant; b_rvalid stays 0.
3. A and B both hold req for 6 cycles after reset, each writing distinct data to its own address -> gnt sequence A,B,A,B,A,B; each requester gets 3 grants; all writes land.
4. A requests while B is idle for 4 cycles -> a_gnt=1 every cycle. Then B requests while A keeps requesting -> B granted on the next cycle (fairness).
5. A read req pending when clr_start asserts, data 0x77 at addr 9 -> no grant for 17 cycles (start cycle + 16 clear cycles); A is granted in the clr_done cycle; rdata=0x00.
6. Assert rst during clear cycle 8 after writing 0xFF to addr 12 -> all outputs 0 immediately, no clr_done. A later read of addr 12 returns 0xFF and of addr 2 returns 0x00.
